// File: rtl/puf_pkg.sv
// puf_pkg: shared types and constants for the voting arbiter PUF.
// Holds the sequencer states, switch encodings and a width helper.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LAUNCH,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [1:0] SW_HOLD = 2'b00;
  localparam logic [1:0] SW_RACE = 2'b11;

  // bits needed to hold 0..n-1, never less than one
  function automatic int unsigned cw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/puf_arb_bank.sv
// puf_arb_bank: array of arbiter cells sharing one switch and challenge.
// Each cell latches its race outcome while the switch is in RACE.
module puf_arb_bank
  import puf_pkg::*;
#(
  parameter int NUM_ARB = 96,
  parameter int CHAL_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        switch_i,
  input  logic [CHAL_W-1:0] challenge_i,
  output logic [NUM_ARB-1:0] resp_o
);

  for (genvar i = 0; i < NUM_ARB; i++) begin : g_cell
    localparam logic [31:0] SEED = 32'(i + 1) * 32'h9E37_79B1;
    localparam logic [CHAL_W-1:0] MASK = CHAL_W'(SEED);

    logic r_resp;

    // cell latches which path won the race for this challenge
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_resp <= 1'b0;
      end else if (switch_i == SW_RACE) begin
        r_resp <= ^(challenge_i & MASK);
      end
    end

    assign resp_o[i] = r_resp;
  end

endmodule

// File: rtl/puf_vote.sv
// puf_vote: repeats arbiter races on one challenge and majority-votes
// each response bit, flagging bits that disagreed across samples.
module puf_vote
  import puf_pkg::*;
#(
  parameter int NUM_ARB       = 96,
  parameter int CHAL_W        = 32,
  parameter int NUM_SAMPLES   = 5,
  parameter int ARM_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int EXT_RESP      = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [CHAL_W-1:0]  challenge_i,
  input  logic [NUM_ARB-1:0] resp_i,
  output logic [1:0]         switch_o,
  output logic [CHAL_W-1:0]  challenge_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [NUM_ARB-1:0] id_o,
  output logic [NUM_ARB-1:0] unstable_o
);

  localparam int CW   = $clog2(NUM_SAMPLES + 1);
  localparam int SCW  = cw(NUM_SAMPLES);
  localparam int TMAX = (ARM_CYCLES > SETTLE_CYCLES) ? ARM_CYCLES
                                                     : SETTLE_CYCLES;
  localparam int TW   = cw(TMAX);

  if (NUM_SAMPLES < 1 || (NUM_SAMPLES % 2) == 0) begin : g_bad_ns
    $error("NUM_SAMPLES must be odd and at least 1");
  end
  if (ARM_CYCLES < 1) begin : g_bad_arm
    $error("ARM_CYCLES must be at least 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  state_t             r_state;
  state_t             w_nstate;
  logic [1:0]         w_sw;
  logic [TW-1:0]      r_tmr;
  logic [SCW-1:0]     r_scnt;
  logic [CHAL_W-1:0]  r_chal;
  logic [CW-1:0]      r_ones [NUM_ARB];
  logic [CW-1:0]      w_ones_nxt [NUM_ARB];
  logic [NUM_ARB-1:0] r_id;
  logic [NUM_ARB-1:0] r_unst;
  logic [NUM_ARB-1:0] w_id;
  logic [NUM_ARB-1:0] w_unst;
  logic [NUM_ARB-1:0] w_bank;
  logic [NUM_ARB-1:0] w_resp;
  logic               w_accept;
  logic               w_last;

  if (EXT_RESP != 0) begin : g_ext
    assign w_bank = '0;
  end else begin : g_int
    puf_arb_bank #(
      .NUM_ARB (NUM_ARB),
      .CHAL_W  (CHAL_W)
    ) u_bank (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .switch_i    (w_sw),
      .challenge_i (r_chal),
      .resp_o      (w_bank)
    );
  end

  assign w_resp   = (EXT_RESP != 0) ? resp_i : w_bank;
  assign w_accept = (r_state == IDLE) && start_i;
  assign w_last   = (r_scnt == SCW'(NUM_SAMPLES - 1));

  // sequencer state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nstate;
  end

  // next state and switch drive
  always_comb begin
    w_nstate = r_state;
    w_sw     = SW_HOLD;
    unique case (r_state)
      IDLE:   if (start_i) w_nstate = ARM;
      ARM:    if (r_tmr == TW'(ARM_CYCLES - 1)) w_nstate = LAUNCH;
      LAUNCH: begin
        w_sw = SW_RACE;
        if (r_tmr == TW'(SETTLE_CYCLES - 1)) w_nstate = SAMPLE;
      end
      SAMPLE: begin
        w_sw     = SW_RACE;
        w_nstate = w_last ? DONE : ARM;
      end
      DONE:   w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  // phase timer restarts on every state change
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmr <= '0;
    end else if (w_nstate != r_state) begin
      r_tmr <= '0;
    end else if (r_state == ARM || r_state == LAUNCH) begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  // vote tallies including the sample being taken this cycle
  always_comb begin
    w_id   = '0;
    w_unst = '0;
    for (int i = 0; i < NUM_ARB; i++) begin
      w_ones_nxt[i] = r_ones[i] + CW'(w_resp[i]);
      w_id[i]   = {w_ones_nxt[i], 1'b0} > (CW + 1)'(NUM_SAMPLES);
      w_unst[i] = (w_ones_nxt[i] != '0) &&
                  (w_ones_nxt[i] != CW'(NUM_SAMPLES));
    end
  end

  // challenge latch, sample count and ones counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_chal <= '0;
      r_scnt <= '0;
      for (int i = 0; i < NUM_ARB; i++) r_ones[i] <= '0;
    end else if (w_accept) begin
      r_chal <= challenge_i;
      r_scnt <= '0;
      for (int i = 0; i < NUM_ARB; i++) r_ones[i] <= '0;
    end else if (r_state == SAMPLE) begin
      r_scnt <= r_scnt + 1'b1;
      for (int i = 0; i < NUM_ARB; i++) r_ones[i] <= w_ones_nxt[i];
    end
  end

  // publish the vote on the edge that enters DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id   <= '0;
      r_unst <= '0;
    end else if (r_state == SAMPLE && w_last) begin
      r_id   <= w_id;
      r_unst <= w_unst;
    end
  end

  assign switch_o    = w_sw;
  assign challenge_o = r_chal;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE);
  assign id_o        = r_id;
  assign unstable_o  = r_unst;

endmodule

// File: tb/tb_puf_vote.sv
// tb_puf_vote: directed vectors for the voting PUF sequencer,
// default timing with external responses plus a one-sample variant.
module tb_puf_vote;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a;
  logic [31:0] chal_a;
  logic [95:0] resp_a;
  logic [1:0]  sw_a;
  logic [31:0] chal_o_a;
  logic        busy_a;
  logic        done_a;
  logic [95:0] id_a;
  logic [95:0] unst_a;

  logic        start_b;
  logic [31:0] chal_b;
  logic [95:0] resp_b;
  logic [1:0]  sw_b;
  logic [31:0] chal_o_b;
  logic        busy_b;
  logic        done_b;
  logic [95:0] id_b;
  logic [95:0] unst_b;

  puf_vote #(
    .NUM_ARB(96), .CHAL_W(32), .NUM_SAMPLES(5),
    .ARM_CYCLES(2), .SETTLE_CYCLES(4), .EXT_RESP(1)
  ) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a),
    .challenge_i(chal_a), .resp_i(resp_a), .switch_o(sw_a),
    .challenge_o(chal_o_a), .busy_o(busy_a), .done_o(done_a),
    .id_o(id_a), .unstable_o(unst_a)
  );

  puf_vote #(
    .NUM_ARB(96), .CHAL_W(32), .NUM_SAMPLES(1),
    .ARM_CYCLES(1), .SETTLE_CYCLES(1), .EXT_RESP(1)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b),
    .challenge_i(chal_b), .resp_i(resp_b), .switch_o(sw_b),
    .challenge_o(chal_o_b), .busy_o(busy_b), .done_o(done_b),
    .id_o(id_b), .unstable_o(unst_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]      chal;
    logic [4:0][95:0] s;
    logic [95:0]      id;
    logic [95:0]      un;
  } vec_t;

  vec_t vt [5];

  localparam logic [95:0] ONES = {96{1'b1}};
  localparam logic [95:0] A5   = {12{8'hA5}};
  localparam logic [95:0] P0F  = {12{8'h0F}};

  // one request on the default instance; cycle n follows start edge k
  task automatic run_a(input int v, input int restart_n,
                       input int abort_n);
    int     sw_bad   = 0;
    int     busy_bad = 0;
    int     ndone    = 0;
    int     done_at  = -1;
    int     nmax;
    int     sidx;
    bit     ab;
    logic [1:0] esw;
    nmax    = (abort_n > 0) ? abort_n + 4 : 38;
    chal_a  = vt[v].chal;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int n = 1; n <= nmax; n++) begin
      sidx = (n - 1) / 7;
      if (sidx > 4) sidx = 4;
      resp_a = vt[v].s[sidx];
      if (n == restart_n) begin
        start_a = 1'b1;
        chal_a  = 32'h0;
      end
      if (abort_n > 0 && n == abort_n) rst = 1'b1;
      ab  = (abort_n > 0) && (n > abort_n);
      esw = (!ab && n <= 35 && ((n - 1) % 7) >= 2) ? 2'b11 : 2'b00;
      if (sw_a !== esw) sw_bad++;
      if (busy_a !== (!ab && n <= 36)) busy_bad++;
      if (done_a === 1'b1) begin
        ndone++;
        done_at = n;
      end
      if (abort_n > 0 && n == abort_n + 1) begin
        chk("abort busy", 96'(busy_a), 96'd0);
        chk("abort done", 96'(done_a), 96'd0);
        chk("abort sw", 96'(sw_a), 96'd0);
        chk("abort id", id_a, 96'd0);
        chk("abort unst", unst_a, 96'd0);
        chk("abort chal", 96'(chal_o_a), 96'd0);
      end
      @(posedge clk); #1;
      start_a = 1'b0;
      rst     = 1'b0;
    end
    chk("switch pattern errs", 96'(sw_bad), 96'd0);
    chk("busy pattern errs", 96'(busy_bad), 96'd0);
    if (abort_n > 0) begin
      chk("done after abort", 96'(ndone), 96'd0);
    end else begin
      chk("done count", 96'(ndone), 96'd1);
      chk("done cycle", 96'(done_at), 96'd36);
      chk("id", id_a, vt[v].id);
      chk("unstable", unst_a, vt[v].un);
      chk("challenge_o", 96'(chal_o_a), 96'(vt[v].chal));
    end
  endtask

  // one request on the single-sample instance
  task automatic run_b(input logic [95:0] r, input logic [31:0] c);
    int ndone   = 0;
    int done_at = -1;
    int sw_bad  = 0;
    logic [1:0] esw;
    resp_b  = r;
    chal_b  = c;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      esw = (n == 2 || n == 3) ? 2'b11 : 2'b00;
      if (sw_b !== esw) sw_bad++;
      if (done_b === 1'b1) begin
        ndone++;
        done_at = n;
      end
      @(posedge clk); #1;
    end
    chk("b switch errs", 96'(sw_bad), 96'd0);
    chk("b done count", 96'(ndone), 96'd1);
    chk("b done cycle", 96'(done_at), 96'd4);
    chk("b id", id_b, r);
    chk("b unstable", unst_b, 96'd0);
    chk("b challenge_o", 96'(chal_o_b), 96'(c));
  endtask

  initial begin
    vt[0].chal = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) vt[0].s[i] = A5;
    vt[0].id = A5;
    vt[0].un = '0;

    vt[1].chal = 32'h01234567;
    vt[1].s[0] = 96'h1;
    vt[1].s[1] = 96'h1;
    vt[1].s[2] = 96'h0;
    vt[1].s[3] = 96'h3;
    vt[1].s[4] = 96'h0;
    vt[1].id = 96'h1;
    vt[1].un = 96'h3;

    vt[2].chal = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) vt[2].s[i] = (i < 3) ? ONES : '0;
    vt[2].id = ONES;
    vt[2].un = ONES;

    vt[3].chal = 32'h5A5A0001;
    for (int i = 0; i < 5; i++) vt[3].s[i] = (i < 3) ? '0 : ONES;
    vt[3].id = '0;
    vt[3].un = ONES;

    vt[4].chal = 32'h0BADC0DE;
    for (int i = 0; i < 5; i++) vt[4].s[i] = (i % 2 == 0) ? P0F : ~P0F;
    vt[4].id = P0F;
    vt[4].un = ONES;

    rst     = 1'b1;
    start_a = 1'b0;
    chal_a  = '0;
    resp_a  = '0;
    start_b = 1'b0;
    chal_b  = '0;
    resp_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset busy", 96'(busy_a), 96'd0);
    chk("reset done", 96'(done_a), 96'd0);
    chk("reset id", id_a, 96'd0);
    chk("reset unst", unst_a, 96'd0);
    chk("reset sw", 96'(sw_a), 96'd0);
    chk("reset chal", 96'(chal_o_a), 96'd0);
    chk("reset b busy", 96'(busy_b), 96'd0);
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) run_a(v, 0, 0);
    run_a(0, 10, 0);
    run_a(1, 0, 20);
    run_a(2, 0, 0);

    run_b(ONES, 32'h12345678);
    run_b(P0F, 32'h87654321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
